// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback-port arbiter.
package wb_arbiter_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         XLEN     = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_fifo.sv
// ALU result FIFO: DEPTH entries of {rd,data}, with a per-slot valid/rd view
// so the parent can build the pending-register mask.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic [AW:0]           count_o,
  output logic [DEPTH-1:0]      ent_vld_o,
  output logic [DEPTH-1:0][4:0] ent_rd_o
);
  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    logic [AW-1:0] off;
    assign off          = AW'(i) - rd_ptr_q;
    assign ent_vld_o[i] = {1'b0, off} < count_q;
    assign ent_rd_o[i]  = mem_q[i].rd;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: loads win, queued ALU results drain in
// order, and an idle port lets a fresh ALU result bypass the queue.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [31:0]     alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [31:0]     mem_data,
  output logic            rf_we,
  output logic [4:0]      rf_addr,
  output logic [31:0]     rf_data,
  output logic [31:0]     pending_mask,
  output logic [AW:0]     fifo_count,
  output logic            waw_err
);
  logic                  alu_acc, alu_wr, mem_win, fifo_ne, push, pop, bypass;
  wb_entry_t             head, push_entry;
  logic [DEPTH-1:0]      ent_vld;
  logic [DEPTH-1:0][4:0] ent_rd;
  logic                  rf_we_q, waw_q;
  logic [4:0]            rf_addr_q;
  logic [XLEN-1:0]       rf_data_q;

  assign alu_ready  = fifo_count < (AW+1)'(DEPTH);
  assign alu_acc    = alu_valid && alu_ready;
  assign alu_wr     = alu_acc && (alu_rd != REG_ZERO);
  assign mem_win    = mem_valid && (mem_rd != REG_ZERO);
  assign fifo_ne    = fifo_count != '0;
  assign push       = alu_wr && (mem_win || fifo_ne);
  assign pop        = !mem_win && fifo_ne;
  assign bypass     = !mem_win && !fifo_ne && alu_wr;
  assign push_entry = '{rd: alu_rd, data: alu_data};

  wb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (fifo_count),
    .ent_vld_o    (ent_vld),
    .ent_rd_o     (ent_rd)
  );

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i]) pending_mask[ent_rd[i]] = 1'b1;
  end

  // Address/data hold their last value on idle cycles; only we drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      waw_q     <= 1'b0;
    end else begin
      if (mem_win) begin
        rf_we_q   <= 1'b1;
        rf_addr_q <= mem_rd;
        rf_data_q <= mem_data;
      end else if (fifo_ne) begin
        rf_we_q   <= 1'b1;
        rf_addr_q <= head.rd;
        rf_data_q <= head.data;
      end else if (bypass) begin
        rf_we_q   <= 1'b1;
        rf_addr_q <= alu_rd;
        rf_data_q <= alu_data;
      end else begin
        rf_we_q   <= 1'b0;
      end
      if (mem_win && pending_mask[mem_rd]) waw_q <= 1'b1;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;
  assign waw_err = waw_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random traffic against a queue-based writeback model.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        alu_valid = 0, mem_valid = 0;
  logic [4:0]  alu_rd = 0, mem_rd = 0;
  logic [31:0] alu_data = 0, mem_data = 0;
  logic        alu_ready, rf_we, waw_err;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data, pending_mask;
  logic [AW:0] fifo_count;

  wb_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .pending_mask(pending_mask), .fifo_count(fifo_count), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: queue of {rd,data} in arrival order plus the expected port state.
  logic [36:0] q[$];
  logic        m_we, m_waw;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i][36:32]] = 1'b1;
    return m;
  endfunction

  task automatic m_reset();
    q.delete();
    m_we = 0; m_addr = 0; m_data = 0; m_waw = 0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".we"},    rf_we, m_we);
    chk({tag, ".addr"},  rf_addr, m_addr);
    chk({tag, ".data"},  rf_data, m_data);
    chk({tag, ".count"}, fifo_count, q.size());
    chk({tag, ".mask"},  pending_mask, m_mask());
    chk({tag, ".waw"},   waw_err, m_waw);
  endtask

  // One clock: drive at negedge, check ready, update model, check after posedge.
  task automatic cycle(input string tag, input logic mv, input logic [4:0] mrd,
                       input logic [31:0] md, input logic av, input logic [4:0] ard,
                       input logic [31:0] ad);
    bit ready, acc;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    #1;
    ready = q.size() < DEPTH;
    chk({tag, ".ready"}, alu_ready, ready);
    acc = av && ready && ard != 0;
    if (mv && mrd != 0) begin
      if (m_mask()[mrd]) m_waw = 1;
      m_we = 1; m_addr = mrd; m_data = md;
      if (acc) q.push_back({ard, ad});
    end else if (q.size() != 0) begin
      m_we = 1; {m_addr, m_data} = q.pop_front();
      if (acc) q.push_back({ard, ad});
    end else if (acc) begin
      m_we = 1; m_addr = ard; m_data = ad;
    end else m_we = 0;
    @(posedge clk); #1;
    chk_out(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_reset();
    #2;
    chk_out("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    idle("post_rst", 1);

    cycle("t1_bypass", 0, 0, 0, 1, 5, 32'hDEADBEEF);
    idle("t1_idle", 1);

    cycle("t2_collide", 1, 3, 32'h11, 1, 7, 32'h22);
    idle("t2_drain", 2);

    for (int i = 0; i < 3; i++)
      cycle("t3_loads", 1, 5'(20 + i), 32'h100 + i, 1, 5'(10 + i), 32'h200 + i);
    for (int i = 0; i < 3; i++)
      cycle("t3_drain", 0, 0, 0, 1, 5'(13 + i), 32'h300 + i);
    idle("t3_idle", 3);

    for (int i = 0; i < 3; i++) cycle("t4_x0", 1, 0, 32'h5, 1, 0, 32'hFFFF);

    cycle("t5_queue", 1, 1, 32'hA, 1, 9, 32'h99);
    cycle("t5_waw", 1, 9, 32'hB, 0, 0, 0);
    idle("t5_drain", 3);

    for (int i = 0; i < 400; i++) begin
      logic        mv, av;
      logic [4:0]  mrd, ard;
      mv  = $urandom_range(0, 9) < 4;
      av  = $urandom_range(0, 9) < 6;
      mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle("rand", mv, mrd, $urandom, av, ard, $urandom);
    end
    idle("rand_drain", 3);

    cycle("t6_fill", 1, 1, 32'h1, 1, 10, 32'hA0);
    cycle("t6_fill", 1, 2, 32'h2, 1, 11, 32'hB0);
    #2 rst_n = 0;
    #1;
    m_reset();
    chk_out("t6_async");
    chk("t6_async.ready", alu_ready, 1'b1);
    @(negedge clk);
    rst_n = 1;
    idle("t6_release", 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port between two writeback producers.
  - ALU/execute results: one cycle each, back-pressurable.
  - Memory load returns: variable latency, cannot be stalled.
- Sits between the execute/memory stages and the register file, in place of the plain writeback register.
- Buffers ALU results in a small FIFO while loads own the port.
- Presents a registered write (we/addr/data) to the register file, plus a pending-register mask for hazard logic.

Parameters:
- DEPTH, 2, ALU result FIFO entries (power of two, 2..8)
- AW, 1, FIFO pointer width, log2(DEPTH)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU result offered this cycle
- alu_rd  input  5  ALU destination register
- alu_data  input  32  ALU result
- alu_ready  output  1  ALU result accepted when alu_valid&&alu_ready
- mem_valid  input  1  load data returning this cycle; always accepted
- mem_rd  input  5  load destination register
- mem_data  input  32  load data, already extended
- rf_we  output  1  register-file write enable, registered
- rf_addr  output  5  register-file write address, registered
- rf_data  output  32  register-file write data, registered
- pending_mask  output  32  bit n set while an ALU write to xn is queued in the FIFO
- fifo_count  output  AW+1  occupied FIFO entries
- waw_err  output  1  sticky collision flag, cleared only by reset

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_addr=0, rf_data=0, FIFO empty (pointers=0, fifo_count=0), pending_mask=0, waw_err=0. Reset mid-operation discards all queued entries; no write is issued on the first edge after release.
- alu_ready = (fifo_count < DEPTH). This is combinational from registered state only; it never depends on alu_valid or mem_valid.
- x0 handling: a valid input with rd==0 is consumed (ALU counts as accepted) but never written and never enqueued.
- Per-cycle port selection, priority order:
  1. mem_valid && mem_rd!=0: the port writes mem_rd/mem_data. An accepted ALU result is enqueued.
  2. Else FIFO non-empty: the port writes the head entry and pops it. An accepted ALU result is enqueued in the same cycle; push and pop together leave the count unchanged.
  3. Else ALU accepted && alu_rd!=0: bypass; the port writes alu_rd/alu_data and nothing is enqueued.
  4. Else rf_we<=0. rf_addr/rf_data hold their previous values.
- Latency: winning source to rf_we is exactly 1 clk. A queued ALU result waits one additional cycle per occupied slot ahead of it and per load cycle.
- Full FIFO:
  - alu_ready=0.
  - A load in that cycle still wins; the FIFO stays full.
  - The next non-load cycle pops the head and reasserts alu_ready.
- Ordering: queued ALU results retire in strict arrival order. Loads may overtake queued ALU results.
- pending_mask: OR of one-hot(rd) over valid FIFO entries, recomputed from the FIFO contents each cycle. Bypassed writes never set a bit.
- waw_err is set on any cycle where the load path wins with mem_rd!=0 and mem_rd matches a valid queued entry's rd. Producers must never cause this; the write still proceeds.
- Pointer wrap: rd/wr pointers are AW bits and wrap modulo DEPTH. Full/empty are derived from fifo_count.

Decomposition:
- Shared package holds:
  - constant REG_ZERO = 5'd0
  - constant XLEN = 32
  - typedef wb_entry_t {rd[4:0], data[31:0]}
- One sub-module is natural: wb_fifo (DEPTH×37-bit synchronous FIFO with push, pop, count, and an entry-valid/rd view for the pending mask).
- Priority mux and output register stay in wb_arbiter.

Test Plan:
1. Reset, then a single ALU rd=5 data=0xDEADBEEF with FIFO empty -> next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF, fifo_count stays 0.
2. Same cycle: mem rd=3 data=0x11 and ALU rd=7 data=0x22 -> cycle+1 writes x3=0x11 with pending_mask=0x80; cycle+2 writes x7=0x22 and pending_mask=0.
3. Three consecutive loads plus ALU issuing every cycle with DEPTH=2 -> alu_ready drops after 2 enqueues, and load writes remain uninterrupted. The first non-load cycle pops the head and raises alu_ready; results then retire in arrival order.
4. ALU rd=0 data=0xFFFF and mem rd=0 -> alu_ready stays 1, rf_we=0 every cycle, fifo_count=0.
5. Queue ALU rd=9, then load mem rd=9 while it is still queued -> waw_err=1 and stays set; both writes occur, load first.
6. Assert rst_n=0 asynchronously between edges with fifo_count=2 -> outputs immediately 0, and no queued write appears after release.
